rgb_to_ycrcb: RTL and testbench
===============================

Name: rgb_to_ycrcb

Overview:
Pipelined fixed-point colour-space converter that sits directly upstream of the skin-tone detector. It converts packed 8-bit RGB pixels into packed Y/Cr/Cb words in the layout the detector consumes. It uses a valid/ready handshake on both sides and supports full backpressure.

Parameters:
DATAIN_WIDTH, 32, input word width; only 32 is supported.
DATAOUT_WIDTH, 32, output word width; only 32 is supported.
COEF_FRAC, 8, fractional bits of the coefficients; fixed at 8 and must not be overridden.

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
datain_valid  input  1  input beat valid
datain  input  32  {R[31:24], G[23:16], B[15:8], unused[7:0]}
datain_ready  output  1  block accepts a beat this cycle
dataout_valid  output  1  output beat valid
dataout  output  32  {Y[31:24], Cr[23:16], Cb[15:8], 8'h00}
dataout_ready  input  1  downstream accepts the beat

Behaviour:
- Reset: already decided as reset rst, synchronous, active-high; clock clk.
  - On rst: dataout_valid=0, dataout=0, internal stage valids=0.
  - Any in-flight beats are discarded.
  - datain_ready is 1 in the cycle after reset, because the pipeline is empty.
- Pipeline and stall control:
  - Three register stages: S1 (9 signed products), S2 (three sums plus offset plus rounding), S3 (clamp, which is the dataout register).
  - advance = !dataout_valid | dataout_ready.
  - datain_ready = advance. This is combinational, with no path from datain_valid.
  - When advance=1, all stages shift and each stage valid takes the previous stage's valid.
  - When advance=0, every stage and dataout hold their values.
- Transfers:
  - Input transfer when datain_valid & datain_ready.
  - Output transfer when dataout_valid & dataout_ready.
- Latency and throughput:
  - Latency is 3 cycles from accept to dataout_valid when not stalled.
  - Throughput is 1 beat per cycle.
  - Capacity is 3 beats.
  - Bubbles are squeezed out only while dataout_valid=0.
- Stability: dataout is stable while dataout_valid=1 and dataout_ready=0. Beats are never dropped or duplicated.
- Arithmetic (full range, coefficients ×256, signed):
  - Y  = 77R + 150G + 29B + 128
  - Cb = -43R - 85G + 128B + 32768 + 128
  - Cr = 128R - 107G - 21B + 32768 + 128
  - Products are 17-bit signed; sums are 19-bit signed.
  - Result = sum >>> 8, then clamped to [0,255]. Negative results give 0; results above 255 give 255.
- Output packing: dataout[7:0] is always 0. Input bits [7:0] are ignored.
- Simultaneous events:
  - Input accept and output transfer in the same cycle are both honoured.
  - rst has priority over everything.

Optional Feature:
Macro: RGB2YCC_LIMITED_RANGE_EN
- Defined: BT.601 studio range.
  - Y  = 66R + 129G + 25B + 4096 + 128, clamped to [16,235].
  - Cb = -38R - 74G + 112B + 32768 + 128, clamped to [16,240].
  - Cr = 112R - 94G - 18B + 32768 + 128, clamped to [16,240].
- Undefined: full-range equations above, clamped to [0,255].
- Latency and handshake are identical in both builds.

Decomposition:
- Package rgb2ycc_pkg holds:
  - the coefficient localparams for both ranges, selected by the macro;
  - the offset and rounding constants;
  - the clamp min/max constants;
  - a typedef for the 19-bit signed accumulator.
- Sub-module ycc_channel: one 3-term MAC channel with registered products, registered sum, and clamp. It takes a stage-enable input and coefficient inputs, and is instantiated three times (Y, Cr, Cb). The top level owns the valid chain and the handshake.

Test Plan:
1. Full range, dataout_ready=1, input RGB (255,255,255) → Y=255, Cr=128, Cb=128 (dataout=32'hFF808000), three cycles after accept. Input (0,0,0) → 32'h00808000.
2. Full range, red (255,0,0) → Y=77, Cb=85, Cr=256 clamped to 255 (32'h4DFF5500). Blue (0,0,255) → Y=29, Cr=107, Cb=256 clamped to 255 (32'h1D6BFF00).
3. Backpressure:
   - Hold dataout_ready=0 and offer 5 consecutive beats → exactly 3 accepted, then datain_ready=0, and dataout stays constant.
   - Raise dataout_ready → all 5 beats emerge in order, with no loss or duplication.
4. Random stream with random datain_valid and dataout_ready (10k beats) → scoreboard against the integer reference model shows exact match and order.
5. Assert rst while 2 beats are in flight → next cycle dataout_valid=0 and dataout=0; those beats never appear; the pipeline then accepts new beats normally.
6. With RGB2YCC_LIMITED_RANGE_EN: white → Y=235, Cr=128, Cb=128; black → Y=16, Cr=128, Cb=128; red → Cr=240 after clamp.

Source files
------------

// File: rtl/rgb2ycc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rgb2ycc_pkg
// Description : Shared types, coefficients, offsets and clamp limits for the
//               RGB -> Y/Cr/Cb converter. Coefficients are signed, scaled by
//               2^8. Selecting the range is done with the macro
//               RGB2YCC_LIMITED_RANGE_EN (defined: BT.601 studio range,
//               undefined: full range).
// Revision    : 1.0 - initial release
// ============================================================================
package rgb2ycc_pkg;

   localparam int c_coef_frac = 8;

   typedef logic signed [8:0]  coef_t;   // coefficient, signed, x256
   typedef logic signed [16:0] prod_t;   // pixel x coefficient
   typedef logic signed [18:0] acc_t;    // three products + offset

   // Rounding is folded into every offset (+0.5 LSB before the shift).
   localparam acc_t c_round      = 19'sd128;
   localparam acc_t c_chroma_off = 19'sd32768 + c_round;

`ifdef RGB2YCC_LIMITED_RANGE_EN
   localparam coef_t c_y_r  =  9'sd66;
   localparam coef_t c_y_g  =  9'sd129;
   localparam coef_t c_y_b  =  9'sd25;
   localparam coef_t c_cb_r = -9'sd38;
   localparam coef_t c_cb_g = -9'sd74;
   localparam coef_t c_cb_b =  9'sd112;
   localparam coef_t c_cr_r =  9'sd112;
   localparam coef_t c_cr_g = -9'sd94;
   localparam coef_t c_cr_b = -9'sd18;

   localparam acc_t c_luma_off = 19'sd4096 + c_round;

   localparam logic [7:0] c_y_min = 8'd16;
   localparam logic [7:0] c_y_max = 8'd235;
   localparam logic [7:0] c_c_min = 8'd16;
   localparam logic [7:0] c_c_max = 8'd240;
`else
   localparam coef_t c_y_r  =  9'sd77;
   localparam coef_t c_y_g  =  9'sd150;
   localparam coef_t c_y_b  =  9'sd29;
   localparam coef_t c_cb_r = -9'sd43;
   localparam coef_t c_cb_g = -9'sd85;
   localparam coef_t c_cb_b =  9'sd128;
   localparam coef_t c_cr_r =  9'sd128;
   localparam coef_t c_cr_g = -9'sd107;
   localparam coef_t c_cr_b = -9'sd21;

   localparam acc_t c_luma_off = c_round;

   localparam logic [7:0] c_y_min = 8'd0;
   localparam logic [7:0] c_y_max = 8'd255;
   localparam logic [7:0] c_c_min = 8'd0;
   localparam logic [7:0] c_c_max = 8'd255;
`endif

   // Unsigned 8-bit pixel times signed coefficient, both widened to the
   // product width so the multiply is signed and needs no truncation.
   function automatic prod_t mul_px(input logic [7:0] px, input coef_t c);
      prod_t a;
      prod_t b;
      a = $signed({9'b0, px});
      b = $signed({{8{c[8]}}, c});
      return a * b;
   endfunction

   function automatic acc_t ext_prod(input prod_t p);
      return $signed({{2{p[16]}}, p});
   endfunction

endpackage
`default_nettype wire

// File: rtl/ycc_channel.sv
`default_nettype none
// ============================================================================
// Module      : ycc_channel
// Description : One output channel of the colour converter: three registered
//               products, a registered sum (with offset and rounding), and a
//               registered clamp. All three stages move only when i_en is 1.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_en              - stage enable (pipeline advance)
//               i_r/i_g/i_b       - 8-bit pixel components
//               i_coef_r/g/b      - signed coefficients (x256)
//               i_offset          - offset plus rounding constant
//               i_min/i_max       - clamp limits
//               o_val             - clamped 8-bit channel value
// Revision    : 1.0 - initial release
// ============================================================================
module ycc_channel
   import rgb2ycc_pkg::*;
#(
   parameter int COEF_FRAC = c_coef_frac
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_en,
   input  logic [7:0] i_r,
   input  logic [7:0] i_g,
   input  logic [7:0] i_b,
   input  coef_t      i_coef_r,
   input  coef_t      i_coef_g,
   input  coef_t      i_coef_b,
   input  acc_t       i_offset,
   input  logic [7:0] i_min,
   input  logic [7:0] i_max,
   output logic [7:0] o_val
);

   prod_t      r_p_r;
   prod_t      r_p_g;
   prod_t      r_p_b;
   acc_t       r_sum;
   logic [7:0] r_out;

   acc_t       w_q;
   acc_t       w_min;
   acc_t       w_max;
   logic [7:0] w_clamped;

   // S1: products
   always_ff @(posedge clk) begin
      if (rst) begin
         r_p_r <= '0;
         r_p_g <= '0;
         r_p_b <= '0;
      end else if (i_en) begin
         r_p_r <= mul_px(i_r, i_coef_r);
         r_p_g <= mul_px(i_g, i_coef_g);
         r_p_b <= mul_px(i_b, i_coef_b);
      end
   end

   // S2: sum of products plus offset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sum <= '0;
      end else if (i_en) begin
         r_sum <= ext_prod(r_p_r) + ext_prod(r_p_g) + ext_prod(r_p_b) + i_offset;
      end
   end

   // S3: drop the fractional bits and saturate to the channel range.
   always_comb begin
      w_q   = r_sum >>> COEF_FRAC;
      w_min = $signed({11'b0, i_min});
      w_max = $signed({11'b0, i_max});
      if (w_q < w_min) begin
         w_clamped = i_min;
      end else if (w_q > w_max) begin
         w_clamped = i_max;
      end else begin
         w_clamped = w_q[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out <= '0;
      end else if (i_en) begin
         r_out <= w_clamped;
      end
   end

   assign o_val = r_out;

endmodule
`default_nettype wire

// File: rtl/rgb_to_ycrcb.sv
`default_nettype none
// ============================================================================
// Module      : rgb_to_ycrcb
// Description : Three-stage pipelined RGB -> Y/Cr/Cb converter with a
//               valid/ready handshake on both sides and full backpressure.
//               Build option: RGB2YCC_LIMITED_RANGE_EN selects BT.601 studio
//               range; otherwise full range.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               datain_valid   - input beat valid
//               datain         - {R[31:24], G[23:16], B[15:8], unused[7:0]}
//               datain_ready   - input beat accepted this cycle when valid
//               dataout_valid  - output beat valid
//               dataout        - {Y[31:24], Cr[23:16], Cb[15:8], 8'h00}
//               dataout_ready  - downstream accepts the output beat
// Revision    : 1.0 - initial release
// ============================================================================
module rgb_to_ycrcb
   import rgb2ycc_pkg::*;
#(
   parameter int DATAIN_WIDTH  = 32,
   parameter int DATAOUT_WIDTH = 32,
   parameter int COEF_FRAC     = c_coef_frac
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     datain_valid,
   input  logic [DATAIN_WIDTH-1:0]  datain,
   output logic                     datain_ready,
   output logic                     dataout_valid,
   output logic [DATAOUT_WIDTH-1:0] dataout,
   input  logic                     dataout_ready
);

   logic       r_v1;
   logic       r_v2;
   logic       r_dout_valid;

   logic       w_advance;
   logic [7:0] w_r;
   logic [7:0] w_g;
   logic [7:0] w_b;
   logic [7:0] w_y;
   logic [7:0] w_cr;
   logic [7:0] w_cb;
   logic       w_unused_lsb;

   // The whole pipeline moves as one; it only stops when the output register
   // holds a beat the consumer is not taking. Empty stages are overwritten,
   // which is what squeezes bubbles out while dataout_valid is low.
   assign w_advance    = !r_dout_valid || dataout_ready;
   assign datain_ready = w_advance;

   assign w_r          = datain[31:24];
   assign w_g          = datain[23:16];
   assign w_b          = datain[15:8];
   assign w_unused_lsb = ^datain[7:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_v1         <= 1'b0;
         r_v2         <= 1'b0;
         r_dout_valid <= 1'b0;
      end else if (w_advance) begin
         r_v1         <= datain_valid;
         r_v2         <= r_v1;
         r_dout_valid <= r_v2;
      end
   end

   ycc_channel #(.COEF_FRAC(COEF_FRAC)) u_ch_y (
      .clk      (clk),
      .rst      (rst),
      .i_en     (w_advance),
      .i_r      (w_r),
      .i_g      (w_g),
      .i_b      (w_b),
      .i_coef_r (c_y_r),
      .i_coef_g (c_y_g),
      .i_coef_b (c_y_b),
      .i_offset (c_luma_off),
      .i_min    (c_y_min),
      .i_max    (c_y_max),
      .o_val    (w_y)
   );

   ycc_channel #(.COEF_FRAC(COEF_FRAC)) u_ch_cr (
      .clk      (clk),
      .rst      (rst),
      .i_en     (w_advance),
      .i_r      (w_r),
      .i_g      (w_g),
      .i_b      (w_b),
      .i_coef_r (c_cr_r),
      .i_coef_g (c_cr_g),
      .i_coef_b (c_cr_b),
      .i_offset (c_chroma_off),
      .i_min    (c_c_min),
      .i_max    (c_c_max),
      .o_val    (w_cr)
   );

   ycc_channel #(.COEF_FRAC(COEF_FRAC)) u_ch_cb (
      .clk      (clk),
      .rst      (rst),
      .i_en     (w_advance),
      .i_r      (w_r),
      .i_g      (w_g),
      .i_b      (w_b),
      .i_coef_r (c_cb_r),
      .i_coef_g (c_cb_g),
      .i_coef_b (c_cb_b),
      .i_offset (c_chroma_off),
      .i_min    (c_c_min),
      .i_max    (c_c_max),
      .o_val    (w_cb)
   );

   assign dataout_valid = r_dout_valid;
   assign dataout       = {w_y, w_cr, w_cb, 8'h00};

endmodule
`default_nettype wire

// File: tb/tb_rgb_to_ycrcb.sv
`default_nettype none
// ============================================================================
// Module      : tb_rgb_to_ycrcb
// Description : Self-checking bench for rgb_to_ycrcb: directed colour points,
//               backpressure, reset flush and a long random stream scored
//               against an integer reference model. Honours
//               RGB2YCC_LIMITED_RANGE_EN for the expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb_to_ycrcb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        datain_valid = 1'b0;
   logic [31:0] datain = '0;
   logic        datain_ready;
   logic        dataout_valid;
   logic [31:0] dataout;
   logic        dataout_ready = 1'b0;

   int checks   = 0;
   int failures = 0;

   logic [31:0] src_q[$];
   logic [31:0] exp_q[$];
   int          accepted  = 0;
   int          delivered = 0;
   logic        prev_hold = 1'b0;
   logic [31:0] prev_data = '0;

   always #5 clk = ~clk;

   rgb_to_ycrcb dut (
      .clk           (clk),
      .rst           (rst),
      .datain_valid  (datain_valid),
      .datain        (datain),
      .datain_ready  (datain_ready),
      .dataout_valid (dataout_valid),
      .dataout       (dataout),
      .dataout_ready (dataout_ready)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Integer reference of the colour equations.
   function automatic int ch(input int cr, input int cg, input int cb, input int off,
                             input int r, input int g, input int b,
                             input int lo, input int hi);
      int s;
      int q;
      s = cr * r + cg * g + cb * b + off;
      q = (s >= 0) ? s / 256 : -((-s + 255) / 256);
      if (q < lo) q = lo;
      if (q > hi) q = hi;
      return q;
   endfunction

   function automatic logic [31:0] ref_ycc(input logic [31:0] px);
      int r, g, b, y, cr, cb;
      r = int'(px[31:24]);
      g = int'(px[23:16]);
      b = int'(px[15:8]);
`ifdef RGB2YCC_LIMITED_RANGE_EN
      y  = ch( 66, 129,  25,  4096 + 128, r, g, b, 16, 235);
      cb = ch(-38, -74, 112, 32768 + 128, r, g, b, 16, 240);
      cr = ch(112, -94, -18, 32768 + 128, r, g, b, 16, 240);
`else
      y  = ch( 77,  150,  29,         128, r, g, b, 0, 255);
      cb = ch(-43,  -85, 128, 32768 + 128, r, g, b, 0, 255);
      cr = ch(128, -107, -21, 32768 + 128, r, g, b, 0, 255);
`endif
      return {y[7:0], cr[7:0], cb[7:0], 8'h00};
   endfunction

   function automatic logic [7:0] rand_comp();
      if ($urandom_range(0, 9) == 0) return ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
      return 8'($urandom_range(0, 255));
   endfunction

   function automatic logic [31:0] rand_px();
      return {rand_comp(), rand_comp(), rand_comp(), 8'($urandom_range(0, 255))};
   endfunction

   // One cycle of streaming: drive at the falling edge, evaluate the
   // handshake 1 ns later, and score whatever transfers at the next rise.
   task automatic step(input logic want_valid, input logic want_ready);
      @(negedge clk);
      datain_valid  = want_valid && (src_q.size() > 0);
      datain        = (src_q.size() > 0) ? src_q[0] : 32'h0;
      dataout_ready = want_ready;
      #1;
      check("ready_rule", 32'(datain_ready), 32'(!dataout_valid || dataout_ready));
      if (prev_hold) begin
         check("hold_valid", 32'(dataout_valid), 32'd1);
         check("hold_data", dataout, prev_data);
      end
      prev_hold = dataout_valid && !dataout_ready;
      prev_data = dataout;
      if (datain_valid && datain_ready) begin
         exp_q.push_back(ref_ycc(src_q.pop_front()));
         accepted++;
      end
      if (dataout_valid && dataout_ready) begin
         if (exp_q.size() == 0) begin
            check("spurious_beat", 32'(dataout_valid), 32'd0);
         end else begin
            check("stream_data", dataout, exp_q.pop_front());
         end
         delivered++;
      end
   endtask

   // Single beat with an idle pipeline: checks value and 3-cycle latency.
   task automatic directed(input string tag, input logic [23:0] rgb, input logic [31:0] exp);
      int lat;
      @(negedge clk);
      datain        = {rgb, 8'h5A};
      datain_valid  = 1'b1;
      dataout_ready = 1'b1;
      #1;
      check({tag, "_accept"}, 32'(datain_ready), 32'd1);
      lat = 0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         datain_valid = 1'b0;
         #1;
         if (dataout_valid && lat == 0) begin
            lat = k;
            check({tag, "_data"}, dataout, exp);
         end
      end
      check({tag, "_latency"}, 32'(lat), 32'd3);
   endtask

   initial begin
      int a0, d0, n;

      // Reset
      repeat (3) @(negedge clk);
      #1;
      check("rst_valid", 32'(dataout_valid), 32'd0);
      check("rst_data", dataout, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      check("post_rst_ready", 32'(datain_ready), 32'd1);
      check("post_rst_valid", 32'(dataout_valid), 32'd0);

      // Directed colour points
`ifdef RGB2YCC_LIMITED_RANGE_EN
      directed("white", 24'hFFFFFF, 32'hEB808000);
      directed("black", 24'h000000, 32'h10808000);
      directed("red",   24'hFF0000, 32'h52F05A00);
      directed("blue",  24'h0000FF, 32'h296EF000);
`else
      directed("white", 24'hFFFFFF, 32'hFF808000);
      directed("black", 24'h000000, 32'h00808000);
      directed("red",   24'hFF0000, 32'h4DFF5500);
      directed("blue",  24'h0000FF, 32'h1D6BFF00);
`endif

      // Backpressure: five beats offered, consumer stalled
      prev_hold = 1'b0;
      for (int i = 0; i < 5; i++) src_q.push_back(rand_px());
      a0 = accepted;
      d0 = delivered;
      repeat (8) step(1'b1, 1'b0);
      check("bp_accepted", 32'(accepted - a0), 32'd3);
      check("bp_ready_low", 32'(datain_ready), 32'd0);
      n = 0;
      while ((delivered - d0) < 5 && n < 20) begin
         step(1'b1, 1'b1);
         n++;
      end
      check("bp_drained", 32'(delivered - d0), 32'd5);

      // Reset with two beats in flight
      for (int i = 0; i < 2; i++) src_q.push_back(rand_px());
      a0 = accepted;
      repeat (2) step(1'b1, 1'b0);
      check("flush_accepted", 32'(accepted - a0), 32'd2);
      @(negedge clk);
      rst          = 1'b1;
      datain_valid = 1'b0;
      @(negedge clk);
      #1;
      check("flush_valid", 32'(dataout_valid), 32'd0);
      check("flush_data", dataout, 32'h0);
      rst = 1'b0;
      exp_q.delete();
      prev_hold = 1'b0;
      repeat (5) step(1'b0, 1'b1);
      src_q.push_back(32'hFF000000);
      d0 = delivered;
      n  = 0;
      while ((delivered - d0) < 1 && n < 10) begin
         step(1'b1, 1'b1);
         n++;
      end
      check("post_flush_beat", 32'(delivered - d0), 32'd1);

      // Random stream
      for (int i = 0; i < 10000; i++) src_q.push_back(rand_px());
      d0 = delivered;
      n  = 0;
      while ((delivered - d0) < 10000 && n < 40000) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
         n++;
      end
      check("rand_delivered", 32'(delivered - d0), 32'd10000);
      check("rand_leftover", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
